// File: rtl/arb_rr_2x1.sv
// Two-input round-robin arbiter with valid/ready handshakes and a registered
// output stage; strict alternation between inputs whenever both contend.
module arb_rr_2x1 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   input  logic             out_ready
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state, state_nxt;
   logic   prio;
   logic   load;
   logic   grant;
   logic   grant_valid;

   // Output register can take a new word when empty or when its word leaves now.
   always_comb begin
      load        = (state == EMPTY) || out_ready;
      grant       = 1'b0;
      if (in0_valid && in1_valid) grant = prio;
      else if (in1_valid)         grant = 1'b1;
      grant_valid = load && (in0_valid || in1_valid);
      in0_ready   = grant_valid && !grant && !rst;
      in1_ready   = grant_valid &&  grant && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load) state_nxt = grant_valid ? FULL : EMPTY;
   end

   always_comb begin
      out_valid = (state == FULL);
   end

   // Data, select and pointer move only on a grant; a drain leaves them as-is.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_sel  <= 1'b0;
         prio     <= 1'b0;
      end else if (grant_valid) begin
         out_data <= grant ? in1_data : in0_data;
         out_sel  <= grant;
         prio     <= ~grant;
      end
   end

endmodule
